prng_driver: RTL and testbench
==============================

# prng_driver

Synthesizable initiator for the `prng` Lehmer generator's seed/start/done handshake. It takes a seed and a request count from a host and runs the four-phase `start`/`done` protocol with `prng` once per value. Each result is chained back as the next seed, and results are buffered in a small FIFO behind a valid/ready stream. It sits between `prng` and any consumer of random words, and replaces bench-driven sequencing.

## Interface
Parameters:
- `M_VAL`, 2147483647: constant driven on `prng_m`.
- `A_VAL`, 16807: constant driven on `prng_a`.
- `SEED_INIT`, 1: seed register value after reset.
- `DEPTH`, 4: output FIFO depth, power of two, ≥2.
- `TIMEOUT`, 1024: max cycles spent waiting on any single `prng_done` edge.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `seed_in`  in  32  seed value for `seed_load`.
- `seed_load`  in  1  pulse; loads `seed_in`. Honoured only in IDLE or ERR.
- `req_count`  in  16  number of values to generate.
- `req_go`  in  1  pulse; starts a run of `req_count` values. Honoured only in IDLE.
- `busy`  out  1  high in REQ/REL/WAIT.
- `err`  out  1  sticky timeout flag.
- `out_data`  out  32  FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer pop; a pop occurs when `out_valid` and `out_ready` are both high.
- `prng_m`, `prng_a`  out  32  constants `M_VAL`, `A_VAL`.
- `prng_seed`  out  32  current seed register.
- `prng_start`  out  1  registered start request.
- `prng_cont`  out  1  tied 0.
- `prng_done`  in  1  generator done, synchronous to `clk`.
- `prng_rand`  in  32  generator result, valid while `prng_done` is low after a done pulse.

## Operation
- FSM states: IDLE, REQ, REL, WAIT, ERR.
- IDLE:
  - `seed_load` sets seed ← `seed_in`.
  - `req_go` with `req_count`≠0 sets remaining ← `req_count` and goes to REQ if the FIFO is not full, otherwise to WAIT.
  - `req_go` with `req_count`=0 is a no-op.
  - `seed_load` and `req_go` in the same cycle: the seed loads first and the run uses the new seed.
- REQ:
  - `prng_start`=1.
  - On `prng_done`=1, go to REL with `prng_start`=0 from the next cycle.
- REL:
  - `prng_start`=0.
  - On `prng_done`=0, in that same edge: push `prng_rand` into the FIFO, set seed ← `prng_rand`, and decrement remaining.
  - Then: if remaining was 1, go to IDLE. Otherwise, if the FIFO is now full, go to WAIT; else go to REQ.
- WAIT: go to REQ on the first cycle the FIFO is not full.
- Only one request is ever in flight, and REQ is entered only with a free slot, so the push in REL never overflows.
- Watchdog:
  - The counter clears on entry to REQ and to REL.
  - If it reaches `TIMEOUT` cycles in REQ or REL, go to ERR with `err`=1, `prng_start`=0, and remaining=0.
- ERR:
  - `busy`=0.
  - `req_go` is ignored.
  - `seed_load` clears `err`, loads the seed, and goes to IDLE.
  - FIFO contents are kept and remain drainable.
- FIFO:
  - Pops are independent of the FSM.
  - A pop while empty is ignored.
  - Push and pop in the same cycle keep the occupancy unchanged.
  - Pointers wrap modulo `DEPTH`.
- `seed_load`/`req_go` while busy: ignored, with no side effects.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE; seed = `SEED_INIT`; remaining = 0.
  - `prng_start`=0, `busy`=0, `err`=0.
  - FIFO empty, `out_valid`=0, `out_data`=0.
- `req_go` sampled at edge 0 → `prng_start`=1 and `busy`=1 after edge 0.
- `prng_done` seen high at edge k → `prng_start`=0 after edge k.
- `prng_done` seen low at edge j (in REL) → after edge j: `out_valid`=1 (if the FIFO was empty), `prng_seed` updated, and `prng_start`=1 again when continuing.
- A pop at edge p updates `out_data`/`out_valid` after edge p. `out_data` is the head word, first-word-fall-through.
- `busy` falls after the edge that captures the final value.
- `rst` asserted mid-run: everything returns to reset values immediately and the FIFO is flushed.

## Test plan
- Reset then `seed_load` 1 and `req_count`=4, bench Park-Miller responder with 3-cycle latency, `out_ready`=1 → stream 16807, 282475249, 1622650073, 984943658; `prng_seed`=984943658; `busy` falls.
- Same run with `out_ready`=0, `DEPTH`=4, `req_count`=6:
  - 4 values buffered; FSM holds in WAIT with `prng_start`=0.
  - Popping one value produces exactly one more request.
  - All 6 values arrive in order.
- Handshake check: responder holds `prng_done` high 5 cycles → `prng_start` stays 0 throughout and no capture happens until `prng_done` falls. A `req_go` pulse mid-run is ignored.
- Responder never asserts `prng_done`, `TIMEOUT`=16 → `err`=1 16 cycles after entering REQ, `busy`=0, `req_go` ignored; `seed_load` clears `err` and the next run succeeds.
- Edge cases:
  - `req_count`=0 → no `prng_start` ever.
  - `seed_load` of 1 plus `req_go` in the same cycle → first output is 16807.
- Assert `rst` low while in REL with 2 values buffered → all outputs reach reset values asynchronously, `out_valid`=0, and `prng_seed`=`SEED_INIT`.

Source files
------------

// File: rtl/prng_driver.sv
// prng_driver: sequences the prng seed/start/done four-phase handshake,
// chains each result back as the next seed, and buffers results in a
// small first-word-fall-through FIFO behind a valid/ready stream.
module prng_driver #(
    parameter logic [31:0] M_VAL     = 32'd2147483647,
    parameter logic [31:0] A_VAL     = 32'd16807,
    parameter logic [31:0] SEED_INIT = 32'd1,
    parameter int          DEPTH     = 4,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed_in,
    input  logic        seed_load,
    input  logic [15:0] req_count,
    input  logic        req_go,
    output logic        busy,
    output logic        err,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] prng_m,
    output logic [31:0] prng_a,
    output logic [31:0] prng_seed,
    output logic        prng_start,
    output logic        prng_cont,
    input  logic        prng_done,
    input  logic [31:0] prng_rand
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [WW-1:0] TIMEOUT_M1 = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_WAIT, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [31:0]   seed_q, seed_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // FIFO bookkeeping; the push only happens on the REL capture edge,
    // and REQ is only entered with a free slot, so it never overflows.
    always_comb begin
        pop      = (count_q != '0) && out_ready;
        push     = (state_q == S_REL) && !prng_done;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = prng_rand;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sequencer next state; the watchdog counts cycles spent in REQ/REL
    // and clears whenever one of those states is (re)entered.
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        remaining_d = remaining_q;
        wd_d        = wd_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (seed_load) seed_d = seed_in;
                if (req_go && (req_count != 16'd0)) begin
                    remaining_d = req_count;
                    wd_d        = '0;
                    state_d     = (count_q == DEPTH_C) ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                if (prng_done) begin
                    state_d = S_REL;
                    wd_d    = '0;
                end else if (wd_q == TIMEOUT_M1) begin
                    state_d     = S_ERR;
                    err_d       = 1'b1;
                    remaining_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_REL: begin
                if (!prng_done) begin
                    seed_d      = prng_rand;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 16'd1) begin
                        state_d = S_IDLE;
                    end else if (count_d == DEPTH_C) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                        wd_d    = '0;
                    end
                end else if (wd_q == TIMEOUT_M1) begin
                    state_d     = S_ERR;
                    err_d       = 1'b1;
                    remaining_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (count_q != DEPTH_C) begin
                    state_d = S_REQ;
                    wd_d    = '0;
                end
            end
            S_ERR: begin
                if (seed_load) begin
                    seed_d  = seed_in;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_REQ);
        busy_d  = (state_d == S_REQ) || (state_d == S_REL) || (state_d == S_WAIT);
    end

    // All state, including FIFO storage, resets asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            seed_q      <= SEED_INIT;
            remaining_q <= '0;
            wd_q        <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            remaining_q <= remaining_d;
            wd_q        <= wd_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign busy       = busy_q;
    assign err        = err_q;
    assign prng_start = start_q;
    assign prng_seed  = seed_q;
    assign prng_m     = M_VAL;
    assign prng_a     = A_VAL;
    assign prng_cont  = 1'b0;

endmodule

// File: tb/tb_prng_driver.sv
// Bench for prng_driver: a Park-Miller responder, a scoreboard fed by a
// behavioural Lehmer model, table-driven runs, random runs and a few
// hand-written multi-cycle sequences.
module tb_prng_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] seed_in = '0;
    logic        seed_load = 1'b0;
    logic [15:0] req_count = '0;
    logic        req_go = 1'b0;
    logic        busy, err, out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [31:0] prng_m, prng_a, prng_seed;
    logic        prng_start, prng_cont;
    logic        prng_done = 1'b0;
    logic [31:0] prng_rand = '0;

    always #5 clk = ~clk;

    prng_driver #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_load(seed_load),
        .req_count(req_count), .req_go(req_go), .busy(busy), .err(err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .prng_m(prng_m), .prng_a(prng_a), .prng_seed(prng_seed),
        .prng_start(prng_start), .prng_cont(prng_cont),
        .prng_done(prng_done), .prng_rand(prng_rand)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] lehmer(input logic [31:0] s);
        longint unsigned p;
        p = {32'd0, s} * 64'd16807;
        return 32'(p % 64'd2147483647);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Responder: four-phase prng model with programmable latency and
    // done-hold time; checks start stays low and no capture happens while done is high.
    int          lat = 3, hold = 0, phase = 0, rcnt = 0;
    bit          resp_en = 1'b1;
    logic [31:0] held_seed = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prng_done = 1'b0;
            phase     = 0;
            rcnt      = 0;
        end else begin
            case (phase)
                0: if (resp_en && prng_start) begin rcnt = 0; phase = 1; end
                1: if (rcnt >= lat) begin
                       prng_done = 1'b1;
                       prng_rand = lehmer(prng_seed);
                       phase     = 2;
                   end else rcnt++;
                2: if (!prng_start) begin rcnt = 0; held_seed = prng_seed; phase = 3; end
                3: begin
                       chk("start_low_while_done", {31'd0, prng_start}, 32'd0);
                       chk("no_capture_while_done", prng_seed, held_seed);
                       if (rcnt >= hold) begin prng_done = 1'b0; phase = 0; end
                       else rcnt++;
                   end
                default: phase = 0;
            endcase
        end
    end

    // Rising edges of prng_start, i.e. requests issued.
    int   starts = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (prng_start && !prev_start) starts++;
        prev_start = prng_start;
    end

    // Consumer + scoreboard: drives out_ready, logs and checks every pop.
    int          cons_mode = 1;
    int          tok_req = 0, tok_done = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    always @(negedge clk) begin
        case (cons_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(1, 0));
            3:       out_ready = (tok_done < tok_req);
            default: out_ready = 1'b0;
        endcase
        if (rst && out_valid && out_ready) begin
            if (cons_mode == 3) tok_done++;
            got_q.push_back(out_data);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %0d expected no word", out_data);
            end else begin
                chk("stream_word", out_data, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic [31:0] seed;
        int          cnt;
        int          lat;
        int          hold;
        int          mode;
        bit          poke;
        logic [31:0] exp_first;
        logic [31:0] exp_seed;
    } vec_t;

    vec_t vecs[6];

    task automatic model_push(input logic [31:0] seed, input int cnt);
        logic [31:0] s;
        s = seed;
        for (int i = 0; i < cnt; i++) begin
            s = lehmer(s);
            exp_q.push_back(s);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_in_time"}, {31'd0, n < 3000}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base;
        lat = v.lat; hold = v.hold; cons_mode = v.mode; resp_en = 1'b1;
        got_q.delete();
        model_push(v.seed, v.cnt);
        base = starts;
        @(negedge clk);
        seed_in = v.seed; seed_load = 1'b1; req_count = 16'(v.cnt); req_go = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; req_go = 1'b0;
        chk({tag, "_start_after_go"}, {31'd0, prng_start}, (v.cnt != 0) ? 32'd1 : 32'd0);
        chk({tag, "_busy_after_go"}, {31'd0, busy}, (v.cnt != 0) ? 32'd1 : 32'd0);
        if (v.poke) begin
            repeat (4) @(negedge clk);
            seed_in = 32'hDEAD; seed_load = 1'b1; req_count = 16'd7; req_go = 1'b1;
            @(negedge clk);
            seed_load = 1'b0; req_go = 1'b0;
        end
        wait_drain(tag);
        repeat (20) @(negedge clk);
        chk({tag, "_starts"}, starts - base, v.cnt);
        chk({tag, "_words"}, got_q.size(), v.cnt);
        if (v.cnt != 0 && got_q.size() != 0) chk({tag, "_first"}, got_q[0], v.exp_first);
        chk({tag, "_final_seed"}, prng_seed, v.exp_seed);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int          base, n;
        vec_t        rv;
        logic [31:0] s;

        vecs[0] = '{32'd1,         4, 3, 0, 1, 1'b0, 32'd16807,      32'd984943658};
        vecs[1] = '{32'd1,         1, 0, 2, 1, 1'b0, 32'd16807,      32'd16807};
        vecs[2] = '{32'd16807,     2, 1, 0, 2, 1'b0, 32'd282475249,  32'd1622650073};
        vecs[3] = '{32'd5,         0, 3, 0, 1, 1'b0, 32'd0,          32'd5};
        vecs[4] = '{32'd282475249, 2, 2, 1, 2, 1'b0, 32'd1622650073, 32'd984943658};
        vecs[5] = '{32'd1,         3, 3, 5, 1, 1'b1, 32'd16807,      32'd1622650073};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_start", {31'd0, prng_start}, 32'd0);
        chk("rst_seed", prng_seed, 32'd1);
        chk("rst_cont", {31'd0, prng_cont}, 32'd0);
        chk("const_m", prng_m, 32'd2147483647);
        chk("const_a", prng_a, 32'd16807);
        rst = 1'b1;

        // Table-driven runs.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: 6 values, consumer stalled, FIFO of 4.
        lat = 3; hold = 0; cons_mode = 0; resp_en = 1'b1;
        got_q.delete();
        model_push(32'd1, 6);
        base = starts;
        @(negedge clk);
        seed_in = 32'd1; seed_load = 1'b1; req_count = 16'd6; req_go = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; req_go = 1'b0;
        repeat (80) @(negedge clk);
        chk("bp_four_requests", starts - base, 4);
        chk("bp_start_low", {31'd0, prng_start}, 32'd0);
        chk("bp_busy_wait", {31'd0, busy}, 32'd1);
        chk("bp_head", out_data, 32'd16807);
        tok_req++;
        cons_mode = 3;
        repeat (80) @(negedge clk);
        chk("bp_one_more_request", starts - base, 5);
        chk("bp_start_low_again", {31'd0, prng_start}, 32'd0);
        chk("bp_one_popped", got_q.size(), 1);
        cons_mode = 1;
        wait_drain("bp");
        chk("bp_total_requests", starts - base, 6);
        chk("bp_total_words", got_q.size(), 6);
        s = 32'd1;
        for (int i = 0; i < 6; i++) s = lehmer(s);
        chk("bp_final_seed", prng_seed, s);

        // Watchdog: responder silent, TIMEOUT=16.
        resp_en = 1'b0; cons_mode = 1;
        base = starts;
        @(negedge clk);
        seed_in = 32'd5; seed_load = 1'b1; req_count = 16'd3; req_go = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; req_go = 1'b0;
        chk("to_start", {31'd0, prng_start}, 32'd1);
        repeat (15) @(negedge clk);
        chk("to_err_not_yet", {31'd0, err}, 32'd0);
        chk("to_busy_not_yet", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("to_err_set", {31'd0, err}, 32'd1);
        chk("to_busy_low", {31'd0, busy}, 32'd0);
        chk("to_start_low", {31'd0, prng_start}, 32'd0);
        req_count = 16'd2; req_go = 1'b1;
        @(negedge clk);
        req_go = 1'b0;
        repeat (4) @(negedge clk);
        chk("to_go_ignored_busy", {31'd0, busy}, 32'd0);
        chk("to_go_ignored_starts", starts - base, 1);
        chk("to_err_sticky", {31'd0, err}, 32'd1);
        seed_in = 32'd1; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        chk("to_err_cleared", {31'd0, err}, 32'd0);
        chk("to_seed_loaded", prng_seed, 32'd1);
        rv = '{32'd1, 2, 3, 0, 1, 1'b0, 32'd16807, 32'd282475249};
        run_vec(rv, "after_err");

        // Random runs against the model.
        for (int i = 0; i < 8; i++) begin
            rv.seed = $urandom_range(32'h7FFFFFFE, 1);
            rv.cnt  = $urandom_range(8, 1);
            rv.lat  = $urandom_range(4, 0);
            rv.hold = $urandom_range(3, 0);
            rv.mode = 2;
            rv.poke = 1'b0;
            rv.exp_first = lehmer(rv.seed);
            s = rv.seed;
            for (int k = 0; k < rv.cnt; k++) s = lehmer(s);
            rv.exp_seed = s;
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset while in REL with two words buffered.
        lat = 1; hold = 5; cons_mode = 0; resp_en = 1'b1;
        model_push(32'd1, 4);
        base = starts;
        @(negedge clk);
        seed_in = 32'd1; seed_load = 1'b1; req_count = 16'd4; req_go = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; req_go = 1'b0;
        n = 0;
        while (!((starts - base == 3) && (phase == 3)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rm_reached_rel", {31'd0, n < 500}, 32'd1);
        chk("rm_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rm_valid", {31'd0, out_valid}, 32'd0);
        chk("rm_data", out_data, 32'd0);
        chk("rm_busy", {31'd0, busy}, 32'd0);
        chk("rm_start", {31'd0, prng_start}, 32'd0);
        chk("rm_err", {31'd0, err}, 32'd0);
        chk("rm_seed", prng_seed, 32'd1);
        exp_q.delete();
        @(negedge clk);
        #3 rst = 1'b1;
        run_vec(vecs[0], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
